mips_pipe_fwd: RTL and testbench

Parametrised successor to the team's 5-stage pipelined core (IF, ID, EX, MEM, WB), using the same opcode map and 32-bit instruction format. Data width, register count and address widths are configurable, and memories are external ports. Adds full EX forwarding, a load-use interlock, a hardwired-zero R0, write-through register-file bypass and corrected branch polarity. A retire counter and halt flag support testbench observation.

---
 rtl/mips_pipe_fwd.sv | 161 ++++++++++++++++
 tb/tb_mips_pipe_fwd.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mips_pipe_fwd.sv
// mips_pipe_fwd: 5-stage pipelined core with full EX forwarding, load-use interlock and halt/retire observation
module mips_pipe_fwd #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int IAW   = 10,
    parameter int DAW   = 10,
    parameter int CNTW  = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic [IAW-1:0]  imem_addr,
    input  logic [31:0]     imem_data,
    output logic [DAW-1:0]  dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            dmem_we,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            halted,
    output logic [CNTW-1:0] retired
);
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [5:0] OP_NOP = 6'b000000, OP_ADD = 6'b100001, OP_SUB = 6'b100010, OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR = 6'b101000, OP_SLT = 6'b110000, OP_MUL = 6'b100000, OP_ADDI = 6'b001110;
    localparam logic [5:0] OP_SUBI = 6'b001101, OP_SLTI = 6'b010000, OP_LW = 6'b000011, OP_SW = 6'b000110;
    localparam logic [5:0] OP_BEQZ = 6'b011110, OP_BNEQZ = 6'b000111, OP_HLT = 6'b111111;

    function automatic logic f_rr(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
    endfunction
    function automatic logic f_wr(input logic [5:0] op);
        return f_rr(op) || (op inside {OP_ADDI, OP_SUBI, OP_SLTI, OP_LW});
    endfunction
    function automatic logic f_src1(input logic [5:0] op);
        return f_wr(op) || (op inside {OP_SW, OP_BEQZ, OP_BNEQZ});
    endfunction

    logic [IAW-1:0]  r_pc;
    logic [31:0]     r_ifid_ir;
    logic [IAW-1:0]  r_ifid_pc;
    logic [5:0]      r_idex_op, r_exmem_op, r_memwb_op;
    logic [RW-1:0]   r_idex_rd, r_idex_rs1, r_idex_rs2, r_exmem_rd, r_memwb_rd;
    logic [XLEN-1:0] r_idex_a, r_idex_b, r_idex_d, r_idex_imm;
    logic [IAW-1:0]  r_idex_pc;
    logic [XLEN-1:0] r_exmem_alu, r_exmem_sd, r_memwb_alu, r_memwb_ld;
    logic [XLEN-1:0] r_rf [NREGS];
    logic            r_halted;
    logic [CNTW-1:0] r_retired;

    logic [5:0]      w_id_op;
    logic [RW-1:0]   w_id_rd, w_id_rs1, w_id_rs2;
    logic [XLEN-1:0] w_imm, w_id_a, w_id_b, w_id_d;
    logic            w_wb_wr, w_mem_fw, w_imm_op, w_taken, w_stall, w_hstop;
    logic [XLEN-1:0] w_wb_val, w_fa, w_fb, w_fd, w_opb, w_alu;
    logic [IAW-1:0]  w_target;

    assign w_id_op  = r_ifid_ir[31:26];
    assign w_id_rd  = r_ifid_ir[21 +: RW];
    assign w_id_rs1 = r_ifid_ir[16 +: RW];
    assign w_id_rs2 = r_ifid_ir[11 +: RW];
    assign w_imm    = XLEN'($signed(r_ifid_ir[15:0]));

    // WB result, also bypassed into same-cycle ID reads of the register file
    assign w_wb_wr  = f_wr(r_memwb_op) && (r_memwb_rd != '0);
    assign w_wb_val = (r_memwb_op == OP_LW) ? r_memwb_ld : r_memwb_alu;
    assign w_id_a   = (w_id_rs1 == '0) ? '0 : (w_wb_wr && r_memwb_rd == w_id_rs1) ? w_wb_val : r_rf[w_id_rs1];
    assign w_id_b   = (w_id_rs2 == '0) ? '0 : (w_wb_wr && r_memwb_rd == w_id_rs2) ? w_wb_val : r_rf[w_id_rs2];
    assign w_id_d   = (w_id_rd == '0) ? '0 : (w_wb_wr && r_memwb_rd == w_id_rd) ? w_wb_val : r_rf[w_id_rd];

    // EX operand forwarding: EX/MEM first, then MEM/WB, else the value latched in ID
    assign w_mem_fw = f_wr(r_exmem_op) && (r_exmem_rd != '0);
    assign w_fa = (w_mem_fw && r_exmem_rd == r_idex_rs1) ? r_exmem_alu : (w_wb_wr && r_memwb_rd == r_idex_rs1) ? w_wb_val : r_idex_a;
    assign w_fb = (w_mem_fw && r_exmem_rd == r_idex_rs2) ? r_exmem_alu : (w_wb_wr && r_memwb_rd == r_idex_rs2) ? w_wb_val : r_idex_b;
    assign w_fd = (w_mem_fw && r_exmem_rd == r_idex_rd) ? r_exmem_alu : (w_wb_wr && r_memwb_rd == r_idex_rd) ? w_wb_val : r_idex_d;

    assign w_imm_op = r_idex_op inside {OP_ADDI, OP_SUBI, OP_SLTI, OP_LW, OP_SW};
    assign w_opb    = w_imm_op ? r_idex_imm : w_fb;
    assign w_alu    = (r_idex_op inside {OP_ADD, OP_ADDI, OP_LW, OP_SW}) ? w_fa + w_opb :
                      (r_idex_op inside {OP_SUB, OP_SUBI}) ? w_fa - w_opb :
                      (r_idex_op == OP_AND) ? (w_fa & w_fb) :
                      (r_idex_op == OP_OR) ? (w_fa | w_fb) :
                      (r_idex_op inside {OP_SLT, OP_SLTI}) ? XLEN'($signed(w_fa) < $signed(w_opb)) :
                      (r_idex_op == OP_MUL) ? w_fa * w_fb : '0;

    // A taken branch squashes IF/ID and ID/EX, overriding both the interlock and an HLT in ID
    assign w_taken  = (r_idex_op == OP_BEQZ && w_fa == '0) || (r_idex_op == OP_BNEQZ && w_fa != '0);
    assign w_target = r_idex_pc + IAW'(1) + r_idex_imm[IAW-1:0];
    assign w_stall  = !w_taken && r_idex_op == OP_LW && r_idex_rd != '0 &&
                      ((f_src1(w_id_op) && w_id_rs1 == r_idex_rd) || (f_rr(w_id_op) && w_id_rs2 == r_idex_rd) ||
                       (w_id_op == OP_SW && w_id_rd == r_idex_rd));
    assign w_hstop  = w_id_op == OP_HLT || r_idex_op == OP_HLT || r_exmem_op == OP_HLT || r_memwb_op == OP_HLT;

    assign imem_addr  = r_pc;
    assign dmem_addr  = r_exmem_alu[DAW-1:0];
    assign dmem_wdata = r_exmem_sd;
    assign dmem_we    = (r_exmem_op == OP_SW) && !r_halted;
    assign halted     = r_halted;
    assign retired    = r_retired;

    // Fetch and decode stages: PC, IF/ID and ID/EX with stall, squash and halt-drain control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= '0;
            r_ifid_ir  <= '0;
            r_ifid_pc  <= '0;
            r_idex_op  <= OP_NOP;
            r_idex_rd  <= '0;
            r_idex_rs1 <= '0;
            r_idex_rs2 <= '0;
            r_idex_a   <= '0;
            r_idex_b   <= '0;
            r_idex_d   <= '0;
            r_idex_imm <= '0;
            r_idex_pc  <= '0;
        end else if (!r_halted) begin
            r_pc <= w_taken ? w_target : (w_stall || w_hstop) ? r_pc : r_pc + IAW'(1);
            if (w_taken || (!w_stall && w_hstop)) begin
                r_ifid_ir <= '0;
            end else if (!w_stall) begin
                r_ifid_ir <= imem_data;
                r_ifid_pc <= r_pc;
            end
            r_idex_op  <= (w_taken || w_stall) ? OP_NOP : w_id_op;
            r_idex_rd  <= w_id_rd;
            r_idex_rs1 <= w_id_rs1;
            r_idex_rs2 <= w_id_rs2;
            r_idex_a   <= w_id_a;
            r_idex_b   <= w_id_b;
            r_idex_d   <= w_id_d;
            r_idex_imm <= w_imm;
            r_idex_pc  <= r_ifid_pc;
        end
    end

    // Back end: EX/MEM, MEM/WB, register-file write, retire count and halt flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exmem_op  <= OP_NOP;
            r_exmem_rd  <= '0;
            r_exmem_alu <= '0;
            r_exmem_sd  <= '0;
            r_memwb_op  <= OP_NOP;
            r_memwb_rd  <= '0;
            r_memwb_alu <= '0;
            r_memwb_ld  <= '0;
            r_retired   <= '0;
            r_halted    <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else if (!r_halted) begin
            r_exmem_op  <= r_idex_op;
            r_exmem_rd  <= r_idex_rd;
            r_exmem_alu <= w_alu;
            r_exmem_sd  <= w_fd;
            r_memwb_op  <= r_exmem_op;
            r_memwb_rd  <= r_exmem_rd;
            r_memwb_alu <= r_exmem_alu;
            r_memwb_ld  <= dmem_rdata;
            if (w_wb_wr) r_rf[r_memwb_rd] <= w_wb_val;
            if (f_src1(r_memwb_op) || r_memwb_op == OP_HLT) r_retired <= r_retired + CNTW'(1);
            if (r_memwb_op == OP_HLT) r_halted <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mips_pipe_fwd.sv
// tb_mips_pipe_fwd: directed programs with hand-computed results for mips_pipe_fwd
module tb_mips_pipe_fwd;
    localparam logic [5:0] ADD = 6'b100001, SUB = 6'b100010, ADDI = 6'b001110, SUBI = 6'b001101;
    localparam logic [5:0] LW = 6'b000011, SW = 6'b000110, BNEQZ = 6'b000111, HLT = 6'b111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  imem_addr, dmem_addr;
    logic [31:0] imem_data, dmem_wdata, dmem_rdata;
    logic        dmem_we, halted;
    logic [31:0] retired;
    logic [31:0] imem [1024];
    logic [31:0] dmem [1024];
    int          n_chk = 0;
    int          n_pass = 0;
    int          edges, we_n;

    mips_pipe_fwd dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    assign imem_data  = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    // Data memory: filled with a recognisable pattern during reset, written by stores otherwise
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 32'hBAD0_0000 | i;
        end else if (dmem_we) begin
            dmem[dmem_addr] <= dmem_wdata;
        end
    end

    function automatic logic [31:0] fi(input logic [5:0] op, input int rd, input int rs, input int imm);
        return {op, 5'(rd), 5'(rs), 16'(imm)};
    endfunction
    function automatic logic [31:0] fr(input logic [5:0] op, input int rd, input int rs1, input int rs2);
        return {op, 5'(rd), 5'(rs1), 5'(rs2), 11'd0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) imem[i] = 32'd0;
    endtask

    task automatic load_loop(input int n);
        clear_imem();
        imem[0] = fi(ADDI, 1, 0, n);
        imem[1] = fi(SUBI, 1, 1, 1);
        imem[2] = fi(BNEQZ, 0, 1, -2);
        imem[3] = fi(ADDI, 5, 5, 1);
        imem[4] = fi(ADDI, 6, 6, 1);
        imem[5] = {HLT, 26'd0};
    endtask

    task automatic start();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(output int e, output int w);
        e = 0;
        w = 0;
        while (!halted && e < 400) begin
            @(posedge clk);
            #1;
            e++;
            if (dmem_we) w++;
        end
    endtask

    initial begin
        // Dependent ALU pair with no NOPs, and reset state of the outputs
        clear_imem();
        imem[0] = fi(ADDI, 1, 0, 5);
        imem[1] = fi(ADDI, 2, 0, 7);
        imem[2] = fr(ADD, 3, 1, 2);
        imem[3] = fr(SUB, 4, 3, 1);
        imem[4] = {HLT, 26'd0};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", imem_addr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retired", retired, 0);
        chk("rst_we", dmem_we, 0);
        start();
        run_to_halt(edges, we_n);
        chk("alu_edges", edges, 9);
        chk("alu_retired", retired, 5);
        chk("alu_r3", dut.r_rf[3], 12);
        chk("alu_r4", dut.r_rf[4], 7);

        // Store, load, then a load-use consumer
        clear_imem();
        imem[0] = fi(ADDI, 1, 0, 9);
        imem[1] = fi(SW, 1, 0, 0);
        imem[2] = fi(LW, 2, 0, 0);
        imem[3] = fi(ADDI, 3, 2, 1);
        imem[4] = {HLT, 26'd0};
        start();
        run_to_halt(edges, we_n);
        chk("lu_edges", edges, 10);
        chk("lu_r3", dut.r_rf[3], 10);
        chk("lu_mem0", dmem[0], 9);
        chk("lu_we_pulses", we_n, 1);

        // Countdown loop with two taken-branch bubbles per iteration
        load_loop(3);
        start();
        run_to_halt(edges, we_n);
        chk("loop_edges", edges, 18);
        chk("loop_r1", dut.r_rf[1], 0);
        chk("loop_r5", dut.r_rf[5], 1);
        chk("loop_r6", dut.r_rf[6], 1);
        chk("loop_retired", retired, 10);

        // R0 stays zero
        clear_imem();
        imem[0] = fi(ADDI, 0, 0, 55);
        imem[1] = fr(ADD, 2, 0, 0);
        imem[2] = {HLT, 26'd0};
        start();
        run_to_halt(edges, we_n);
        chk("r0_edges", edges, 7);
        chk("r0_r2", dut.r_rf[2], 0);
        chk("r0_retired", retired, 3);

        // Instructions behind HLT never take effect
        clear_imem();
        imem[0] = fi(ADDI, 1, 0, 4);
        imem[1] = fi(SW, 1, 0, 2);
        imem[2] = {HLT, 26'd0};
        imem[3] = fi(ADDI, 5, 0, 1);
        imem[4] = fi(SW, 1, 0, 3);
        start();
        run_to_halt(edges, we_n);
        chk("hlt_edges", edges, 7);
        we_n = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (dmem_we) we_n++;
        end
        chk("hlt_halted", halted, 1);
        chk("hlt_we_after", we_n, 0);
        chk("hlt_r5", dut.r_rf[5], 0);
        chk("hlt_mem2", dmem[2], 4);
        chk("hlt_mem3", dmem[3], 32'hBAD0_0003);
        chk("hlt_pc", imem_addr, 3);
        chk("hlt_retired", retired, 3);

        // Asynchronous reset in the middle of a running loop, then a clean rerun
        load_loop(20);
        start();
        repeat (30) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_pc", imem_addr, 0);
        chk("mid_retired", retired, 0);
        chk("mid_halted", halted, 0);
        chk("mid_we", dmem_we, 0);
        chk("mid_daddr", dmem_addr, 0);
        chk("mid_wdata", dmem_wdata, 0);
        start();
        run_to_halt(edges, we_n);
        chk("rerun_edges", edges, 86);
        chk("rerun_r1", dut.r_rf[1], 0);
        chk("rerun_r5", dut.r_rf[5], 1);
        chk("rerun_retired", retired, 44);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
